// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks a W x H frame in raster order and hands each pixel
// to one of NUM_ENGINES engines via a round-robin ready/valid handshake.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, stop           frame start pulse (IDLE only), abort request (RUN only)
//   cfg_width/cfg_height  frame size, clamped to MAX_WIDTH/MAX_HEIGHT
//   eng_ready             per-engine idle/accept indication
//   pix_valid             one-hot issue strobe, pix_x/pix_y carry the pixel
//   busy                  high in RUN and DRAIN
//   frame_done, aborted   end-of-frame pulse and its abort flag
//   pixels_issued         saturating issue count for the current/last frame
module pixel_dispatcher #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned NUM_ENGINES = 12,
  parameter int unsigned MAX_WIDTH   = 640,
  parameter int unsigned MAX_HEIGHT  = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [COORD_W-1:0]       cfg_width,
  input  logic [COORD_W-1:0]       cfg_height,
  input  logic [NUM_ENGINES-1:0]   eng_ready,
  output logic [NUM_ENGINES-1:0]   pix_valid,
  output logic [COORD_W-1:0]       pix_x,
  output logic [COORD_W-1:0]       pix_y,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     aborted,
  output logic [2*COORD_W-1:0]     pixels_issued
);

  localparam int unsigned PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = 2 * COORD_W;

  localparam logic [COORD_W-1:0]     MAX_W_C     = COORD_W'(MAX_WIDTH);
  localparam logic [COORD_W-1:0]     MAX_H_C     = COORD_W'(MAX_HEIGHT);
  localparam logic [SUM_W-1:0]       NUM_E_C     = SUM_W'(NUM_ENGINES);
  localparam logic [PTR_W-1:0]       LAST_E_C    = PTR_W'(NUM_ENGINES - 1);
  localparam logic [NUM_ENGINES-1:0] ALL_READY_C = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [COORD_W-1:0]     w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_ENGINES-1:0] pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0]     pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   aborted_q, aborted_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_ENGINES-1:0] cand;
  logic [NUM_ENGINES-1:0] cand_rot;
  logic                   gnt_found;
  logic [PTR_W-1:0]       gnt_off;
  logic [SUM_W-1:0]       gnt_sum;
  logic [PTR_W-1:0]       gnt_idx;
  logic [NUM_ENGINES-1:0] gnt_oh;
  logic                   last_px;
  logic                   issue;

  // Round-robin arbiter: rotate candidates so the pointer sits at bit 0,
  // take the lowest set bit, then rotate the offset back to an engine index.
  // The engine issued last cycle is masked since its ready may still be high.
  always_comb begin
    cand     = eng_ready & ~pix_valid_q;
    cand_rot = NUM_ENGINES'({cand, cand} >> ptr_q);
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (cand_rot[i]) begin
        gnt_found = 1'b1;
        gnt_off   = PTR_W'(i);
      end
    end
    gnt_sum = SUM_W'(ptr_q) + SUM_W'(gnt_off);
    if (gnt_sum >= NUM_E_C) begin
      gnt_sum = gnt_sum - NUM_E_C;
    end
    gnt_idx = PTR_W'(gnt_sum);
    gnt_oh  = NUM_ENGINES'(1) << gnt_idx;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    x_d          = x_q;
    y_d          = y_q;
    ptr_d        = ptr_q;
    pix_valid_d  = '0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    frame_done_d = 1'b0;
    aborted_d    = aborted_q;
    cnt_d        = cnt_q;
    last_px      = (x_q == w_q - COORD_W'(1)) && (y_q == h_q - COORD_W'(1));
    issue        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d       = (cfg_width  > MAX_W_C) ? MAX_W_C : cfg_width;
          h_d       = (cfg_height > MAX_H_C) ? MAX_H_C : cfg_height;
          x_d       = '0;
          y_d       = '0;
          cnt_d     = '0;
          aborted_d = 1'b0;
          state_d   = ((w_d == '0) || (h_d == '0)) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // stop suppresses the grant, except when the grant is the last pixel
        issue = gnt_found && (!stop || last_px);
        if (issue) begin
          pix_valid_d = gnt_oh;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          ptr_d       = (gnt_idx == LAST_E_C) ? '0 : gnt_idx + PTR_W'(1);
          if (last_px) begin
            state_d = ST_DRAIN;
          end else if (x_q == w_q - COORD_W'(1)) begin
            x_d = '0;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end else if (stop) begin
          state_d   = ST_DRAIN;
          aborted_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // wait for every engine idle and the final handshake to have landed
        if ((eng_ready == ALL_READY_C) && (pix_valid_q == '0)) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      ptr_q        <= '0;
      pix_valid_q  <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ptr_q        <= ptr_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign aborted       = aborted_q;
  assign pixels_issued = cnt_q;

endmodule

// File: doc/pixel_dispatcher.md
Name: pixel_dispatcher

Overview:
- Next-generation coordinate source for the Mandelbrot engine array.
- Walks a runtime-configurable frame in raster order (x fastest).
- Hands each pixel to one engine through a per-engine ready/valid handshake, arbitrated round-robin, so fast engines are never held back by slow ones.
- Reports frame completion once every engine has gone idle; supports abort.

Parameters:
COORD_W, 10, width of x/y coordinates and of cfg_width/cfg_height.
NUM_ENGINES, 12, number of engines served; range 1..32.
MAX_WIDTH, 640, upper clamp for cfg_width.
MAX_HEIGHT, 480, upper clamp for cfg_height.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; latches cfg and begins a frame; honoured only in IDLE.
stop  in  1  abort request; honoured only in RUN.
cfg_width  in  COORD_W  frame width in pixels.
cfg_height  in  COORD_W  frame height in pixels.
eng_ready  in  NUM_ENGINES  bit k high means engine k is idle and can accept a pixel.
pix_valid  out  NUM_ENGINES  one-hot; bit k high for one cycle hands pix_x/pix_y to engine k.
pix_x  out  COORD_W  x coordinate of the pixel being issued.
pix_y  out  COORD_W  y coordinate of the pixel being issued.
busy  out  1  high in RUN and DRAIN.
frame_done  out  1  one-cycle pulse on return to IDLE.
aborted  out  1  valid with frame_done; 1 if the frame was ended by stop.
pixels_issued  out  2*COORD_W  pixels issued in the current or last frame.

Behaviour:
- Reset: state IDLE. All of pix_valid, pix_x, pix_y, busy, frame_done, aborted, pixels_issued are 0. Round-robin pointer is 0.
- Reset mid-frame: same values, applied on the next edge; outstanding engine work is forgotten.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start: latch W = min(cfg_width, MAX_WIDTH) and H = min(cfg_height, MAX_HEIGHT).
  - Clear pixels_issued and set the internal cursor to (0,0).
  - If W==0 or H==0, go to DRAIN with nothing issued; otherwise go to RUN.
- RUN, each cycle:
  - Candidates are eng_ready with the engine issued in the previous cycle masked off. Engines must drop ready within one cycle of seeing pix_valid.
  - Grant the first candidate at or above the pointer, wrapping modulo NUM_ENGINES. Pointer becomes grant+1 (mod NUM_ENGINES).
  - With a grant: on the next edge pix_valid = onehot(grant), pix_x/pix_y = cursor, pixels_issued increments. Latency from ready to valid is 1 cycle.
  - Without a grant: pix_valid is 0 and the cursor holds.
  - At most one pixel is issued per cycle.
- Cursor advance: x+1. At x==W-1, x wraps to 0 and y increments.
- Last pixel: issuing (W-1, H-1) moves to DRAIN on the same edge.
- stop in RUN:
  - No grant is made that cycle; go to DRAIN with aborted=1.
  - If stop and the last issue coincide, the issue still happens and aborted=0.
- DRAIN: pix_valid is 0. When eng_ready is all-ones and no pix_valid was driven in the previous cycle, pulse frame_done for one cycle and go to IDLE.
- Ignored inputs: start in RUN or DRAIN; stop in IDLE or DRAIN.
- pix_x/pix_y hold their last value when pix_valid is 0.
- Arithmetic: the cursor compares against W-1/H-1 only, with no division or modulo. Coordinates never exceed MAX-1.
- pixels_issued saturates at all-ones and holds its value in IDLE.

Test Plan:
- Reset then start with W=4, H=2, NUM_ENGINES=3, all ready, engines drop ready one cycle after valid and re-raise after 2 cycles -> exactly 8 issues in order (0,0)..(3,1) to engines 0,1,2,0,1,2,0,1; frame_done once; aborted=0; pixels_issued=8.
- W=640, H=480, all ready, 1-cycle engine latency -> 307200 issues; last coordinate (639,479); no coordinate repeated; y increments exactly at x wrap.
- Only engine 5 ever ready (NUM_ENGINES=12) -> every pix_valid is 0x020; no back-to-back issue to engine 5.
- stop asserted after 10 issues, engines busy 20 cycles -> no further issues; frame_done only after all eng_ready high; aborted=1; pixels_issued=10.
- start with cfg_width=0 -> frame_done next DRAIN cycle with all ready; zero issues. cfg_width=1000 -> W clamps to 640.
- reset mid-RUN, then start with W=2, H=2 -> outputs 0 after reset; new frame issues (0,0) first; start pulsed during RUN is ignored.
